// File: rtl/mem_interface_tracked.sv
// Start-bit serial memory link controller.
// TX: frames a command as start bit, header cycles and a variable-length payload onto tx_pins.
// RX: detects start bits on rx_pins and deframes a short or long payload.
// Tracks issued-but-unanswered commands and holds off new commands while the count is full.
module mem_interface_tracked #(
  parameter int IO_BITS            = 2,
  parameter int HEADER_CYCLES      = 1,
  parameter int MAX_PAYLOAD_CYCLES = 8,
  parameter int RX_SHORT_CYCLES    = 2,
  parameter int RX_LONG_CYCLES     = 8,
  parameter int MAX_OUTSTANDING    = 3,
  localparam int TX_CMD_BITS       = IO_BITS * HEADER_CYCLES,
  localparam int CW                = $clog2(MAX_PAYLOAD_CYCLES + 1),
  localparam int OW                = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tx_command_valid,
  input  logic [TX_CMD_BITS-1:0] tx_command,
  input  logic [CW-1:0]          tx_len,
  output logic                   tx_command_started,
  output logic                   tx_active,
  input  logic [IO_BITS-1:0]     tx_data,
  output logic                   tx_data_next,
  output logic [CW-1:0]          tx_counter,
  output logic                   tx_done,
  output logic [OW-1:0]          outstanding,
  output logic                   rx_started,
  output logic [IO_BITS-1:0]     rx_sbs,
  output logic                   rx_long,
  output logic                   rx_data_valid,
  output logic [CW-1:0]          rx_counter,
  output logic                   rx_done,
  output logic                   rx_unexpected,
  output logic [IO_BITS-1:0]     tx_pins,
  input  logic [IO_BITS-1:0]     rx_pins
);

  localparam int HW = (HEADER_CYCLES > 1) ? $clog2(HEADER_CYCLES) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY} tx_state_e;
  typedef enum logic       {RX_IDLE, RX_DATA}        rx_state_e;

  tx_state_e              tx_state_q, tx_state_d;
  logic [TX_CMD_BITS-1:0] tx_cmd_q, tx_cmd_d;
  logic [CW-1:0]          tx_len_q, tx_len_d;
  logic [HW-1:0]          hdr_cnt_q, hdr_cnt_d;
  logic [CW-1:0]          pay_cnt_q, pay_cnt_d;
  rx_state_e              rx_state_q, rx_state_d;
  logic [IO_BITS-1:0]     rx_sbs_q, rx_sbs_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [OW-1:0]          outstanding_q, outstanding_d;

  logic          start;
  logic          hdr_last;
  logic          pay_last;
  logic          rx_last;
  logic [CW-1:0] rx_n;

  // Frame boundaries and the start decision; a full tracker still admits a start when a response completes.
  assign rx_n     = rx_sbs_q[IO_BITS-1] ? CW'(RX_LONG_CYCLES) : CW'(RX_SHORT_CYCLES);
  assign rx_last  = (rx_state_q == RX_DATA) && (rx_cnt_q == rx_n - CW'(1));
  assign hdr_last = (tx_state_q == TX_HDR) && (hdr_cnt_q == HW'(HEADER_CYCLES - 1));
  assign pay_last = (tx_state_q == TX_PAY) && (pay_cnt_q == tx_len_q - CW'(1));
  assign start    = reset_n && (tx_state_q == TX_IDLE) && tx_command_valid &&
                    ((outstanding_q < OW'(MAX_OUTSTANDING)) || rx_last);

  // TX state register and frame context
  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cmd_q   <= '0;
      tx_len_q   <= '0;
      hdr_cnt_q  <= '0;
      pay_cnt_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cmd_q   <= tx_cmd_d;
      tx_len_q   <= tx_len_d;
      hdr_cnt_q  <= hdr_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
    end
  end

  // TX next state: command and length are captured only in the start cycle
  // NOTE: defaults first so every path assigns every variable and no latch is inferred.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cmd_d   = tx_cmd_q;
    tx_len_d   = tx_len_q;
    hdr_cnt_d  = hdr_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (start) begin
          tx_state_d = TX_HDR;
          tx_cmd_d   = tx_command;
          tx_len_d   = tx_len;
          hdr_cnt_d  = '0;
        end
      end
      TX_HDR: begin
        if (hdr_last) begin
          pay_cnt_d  = '0;
          tx_state_d = (tx_len_q == '0) ? TX_IDLE : TX_PAY;
        end else begin
          hdr_cnt_d = hdr_cnt_q + HW'(1);
        end
      end
      TX_PAY: begin
        if (pay_last) begin
          tx_state_d = TX_IDLE;
          pay_cnt_d  = '0;
        end else begin
          pay_cnt_d = pay_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: start bit on pin 0, header slices LSBs first, then payload straight from tx_data
  always_comb begin
    tx_command_started = 1'b0;
    tx_active          = 1'b0;
    tx_data_next       = 1'b0;
    tx_counter         = '0;
    tx_done            = 1'b0;
    tx_pins            = '0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_command_started = start;
        tx_pins            = IO_BITS'(start);
      end
      TX_HDR: begin
        tx_active = 1'b1;
        tx_pins   = tx_cmd_q[int'(hdr_cnt_q) * IO_BITS +: IO_BITS];
        tx_done   = hdr_last && (tx_len_q == '0);
      end
      TX_PAY: begin
        tx_active    = 1'b1;
        tx_data_next = 1'b1;
        tx_pins      = tx_data;
        tx_counter   = pay_cnt_q;
        tx_done      = pay_last;
      end
      default: ;
    endcase
  end

  // RX state register, latched start bits and payload index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_sbs_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sbs_q   <= rx_sbs_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  // RX next state: start bits are only looked for while idle, so payload never restarts a frame
  always_comb begin
    rx_state_d = rx_state_q;
    rx_sbs_d   = rx_sbs_q;
    rx_cnt_d   = rx_cnt_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_pins != '0) begin
          rx_state_d = RX_DATA;
          rx_sbs_d   = rx_pins;
          rx_cnt_d   = '0;
        end
      end
      RX_DATA: begin
        if (rx_last) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX outputs
  always_comb begin
    rx_started    = reset_n && (rx_state_q == RX_IDLE) && (rx_pins != '0);
    rx_data_valid = (rx_state_q == RX_DATA);
    rx_counter    = (rx_state_q == RX_DATA) ? rx_cnt_q : '0;
    rx_done       = rx_last;
    rx_sbs        = rx_sbs_q;
    rx_long       = rx_sbs_q[IO_BITS-1];
  end

  // Outstanding tracker: a start and a matched response in the same cycle cancel out
  always_comb begin
    outstanding_d = outstanding_q;
    rx_unexpected = rx_last && (outstanding_q == '0);
    case ({start, rx_last && (outstanding_q != '0)})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Outstanding count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) outstanding_q <= '0;
    else          outstanding_q <= outstanding_d;
  end

  assign outstanding = outstanding_q;

endmodule
